// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg
// Shared definitions for the RV32M multiply/divide sequencer.
// Holds the funct3 operation encoding, the sequencer FSM states and
// small helpers that classify an operation by kind and signedness.
package muldiv_sequencer_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // All divide/remainder encodings have funct3[2] set
    function automatic logic is_div_op(input op_e i_op);
        return i_op[2];
    endfunction

    // Operand A is treated as signed for every op except the unsigned ones
    function automatic logic a_is_signed(input op_e i_op);
        return (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
               (i_op == OP_DIV) || (i_op == OP_REM);
    endfunction

    // Operand B is unsigned for MULHSU as well as the unsigned ops
    function automatic logic b_is_signed(input op_e i_op);
        return (i_op == OP_MUL) || (i_op == OP_MULH) ||
               (i_op == OP_DIV) || (i_op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// One combinational radix-2 iteration on unsigned magnitudes.
// Multiply: LSB-first shift-add, {acc,lo} holds partial product / multiplier.
// Divide:   restoring division, acc is the partial remainder and lo shifts
//           the dividend out at the top while quotient bits enter at the bottom.
// Ports:
//   i_is_div  - 1 selects divide step, 0 selects multiply step
//   i_acc     - upper working register (product high / remainder)
//   i_lo      - lower working register (multiplier / dividend+quotient)
//   i_operand - multiplicand or divisor magnitude
//   o_acc     - next value of acc
//   o_lo      - next value of lo
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_is_div,
    input  logic [DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0] i_lo,
    input  logic [DATA_WIDTH-1:0] i_operand,
    output logic [DATA_WIDTH-1:0] o_acc,
    output logic [DATA_WIDTH-1:0] o_lo
);
    localparam int W = DATA_WIDTH;

    logic [W:0]   w_sum;
    logic [W:0]   w_shifted;
    logic [W-1:0] w_diff;
    logic         w_ge;

    // Both step flavours are computed and the op kind picks one.
    // The remainder stays below the divisor, so the shifted value fits in
    // W+1 bits and a W-bit subtraction is exact whenever it is kept.
    always_comb begin
        w_sum     = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_operand} : '0);
        w_shifted = {i_acc, i_lo[W-1]};
        w_ge      = (w_shifted >= {1'b0, i_operand});
        w_diff    = w_shifted[W-1:0] - i_operand;
        if (i_is_div) begin
            o_acc = w_ge ? w_diff : w_shifted[W-1:0];
            o_lo  = {i_lo[W-2:0], w_ge};
        end else begin
            o_acc = w_sum[W:1];
            o_lo  = {w_sum[0], i_lo[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Operands are converted to magnitudes on accept, iterated DATA_WIDTH times,
// then sign-corrected in a single fix-up cycle. Divide-by-zero and signed
// overflow bypass the iteration and go straight to DONE.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - synchronous abort back to IDLE
//   in_valid, in_ready  - request handshake (in_ready only in IDLE)
//   op                  - RV32M funct3
//   operand_A/operand_B - rs1 / rs2 values
//   out_valid, out_ready- result handshake
//   result              - RV32M result, held until taken
//   div_by_zero         - divide op with operand_B == 0, qualified by out_valid
//   busy                - high whenever not IDLE
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  div_by_zero,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    state_e       r_state;
    state_e       w_next;
    op_e          r_op;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_lo;
    logic [W-1:0] r_mcand;
    logic [W-1:0] r_result;
    logic         r_negA;
    logic         r_negB;
    logic         r_dbz;
    logic [CW-1:0] r_cnt;

    op_e          w_op;
    logic         w_accept;
    logic         w_negA;
    logic         w_negB;
    logic [W-1:0] w_magA;
    logic [W-1:0] w_magB;
    logic         w_divZero;
    logic         w_ovf;
    logic         w_lastStep;
    logic [W-1:0] w_stepAcc;
    logic [W-1:0] w_stepLo;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prodFix;
    logic [W-1:0] w_quot;
    logic [W-1:0] w_rem;
    logic [W-1:0] w_fixResult;

    // Accept qualification, magnitude conversion and fast-path detection.
    // flush blocks acceptance so an aborted cycle never latches a request.
    always_comb begin
        w_op       = op_e'(op);
        w_accept   = in_valid && (r_state == ST_IDLE) && !flush;
        w_negA     = a_is_signed(w_op) && operand_A[W-1];
        w_negB     = b_is_signed(w_op) && operand_B[W-1];
        w_magA     = w_negA ? -operand_A : operand_A;
        w_magB     = w_negB ? -operand_B : operand_B;
        w_divZero  = is_div_op(w_op) && (operand_B == '0);
        w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                     (operand_A == MIN_VAL) && (operand_B == '1);
        w_lastStep = (r_cnt == CW'(W - 1));
    end

    muldiv_step #(.DATA_WIDTH(W)) u_step (
        .i_is_div  (is_div_op(r_op)),
        .i_acc     (r_acc),
        .i_lo      (r_lo),
        .i_operand (r_mcand),
        .o_acc     (w_stepAcc),
        .o_lo      (w_stepLo)
    );

    // Sign fix-up and result selection applied in the FIX cycle.
    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    always_comb begin
        w_prod    = {r_acc, r_lo};
        w_prodFix = (r_negA ^ r_negB) ? -w_prod : w_prod;
        w_quot    = (r_negA ^ r_negB) ? -r_lo : r_lo;
        w_rem     = r_negA ? -r_acc : r_acc;
        case (r_op)
            OP_MUL:                        w_fixResult = w_prodFix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fixResult = w_prodFix[2*W-1:W];
            OP_DIV, OP_DIVU:               w_fixResult = w_quot;
            default:                       w_fixResult = w_rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush wins over every other transition
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) w_next = (w_divZero || w_ovf) ? ST_DONE : ST_CALC;
                ST_CALC: if (w_lastStep) w_next = ST_FIX;
                ST_FIX:  w_next = ST_DONE;
                ST_DONE: if (out_ready) w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs; in_ready depends only on state so a handoff cycle never accepts
    always_comb begin
        in_ready    = (r_state == ST_IDLE);
        busy        = (r_state != ST_IDLE);
        out_valid   = (r_state == ST_DONE);
        result      = r_result;
        div_by_zero = r_dbz;
    end

    // Datapath: latch on accept, iterate in CALC, write result in FIX.
    // For divide-by-zero, funct3[1] separates remainder ops from quotient ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_MUL;
            r_acc    <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_result <= '0;
            r_negA   <= 1'b0;
            r_negB   <= 1'b0;
            r_dbz    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_op    <= w_op;
            r_negA  <= w_negA;
            r_negB  <= w_negB;
            r_acc   <= '0;
            r_lo    <= w_magA;
            r_mcand <= w_magB;
            r_cnt   <= '0;
            if (w_divZero) begin
                r_result <= w_op[1] ? operand_A : '1;
                r_dbz    <= 1'b1;
            end else if (w_ovf) begin
                r_result <= (w_op == OP_DIV) ? operand_A : '0;
                r_dbz    <= 1'b0;
            end else begin
                r_dbz    <= 1'b0;
            end
        end else if (r_state == ST_CALC) begin
            r_acc <= w_stepAcc;
            r_lo  <= w_stepLo;
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == ST_FIX) begin
            r_result <= w_fixResult;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Directed self-checking bench for muldiv_sequencer at the default 32-bit width.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request at a negedge and return once the accept edge has passed
    task automatic issue(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op        = opc;
        operand_A = a;
        operand_B = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count negedges after accept until out_valid is seen, bounded
    task automatic waitValid(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!out_valid && cycles < 100);
    endtask

    // One full transaction with out_ready held high
    task automatic applyStimulus(input string tag, input logic [2:0] opc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expResult, input logic expDbz,
                                 input int expLat);
        int cycles;
        out_ready = 1'b1;
        issue(opc, a, b);
        waitValid(cycles);
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_lat"}, 32'(cycles), 32'(expLat));
        checkOutput({tag, "_res"}, result, expResult);
        checkOutput({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, expDbz});
    endtask

    initial begin
        int cycles;
        int seenValid;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        operand_A = '0;
        operand_B = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed arithmetic vectors
        applyStimulus("mul_7_m3",     3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34);
        applyStimulus("mul_shift",    3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, 34);
        applyStimulus("mulh_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34);
        applyStimulus("mulhu_max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
        applyStimulus("mulhsu_m1_2",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 34);
        applyStimulus("div_m20_3",    3'b100, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 1'b0, 34);
        applyStimulus("rem_m20_3",    3'b110, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 1'b0, 34);
        applyStimulus("div_20_m3",    3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, 34);
        applyStimulus("rem_20_m3",    3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         1'b0, 34);
        applyStimulus("divu_100_7",   3'b101, 32'd100,       32'd7,         32'd14,        1'b0, 34);
        applyStimulus("remu_100_7",   3'b111, 32'd100,       32'd7,         32'd2,         1'b0, 34);

        // Fast paths
        applyStimulus("divu_by0",     3'b101, 32'd123,       32'd0,         32'hFFFF_FFFF, 1'b1, 1);
        applyStimulus("rem_by0",      3'b110, 32'd123,       32'd0,         32'd123,       1'b1, 1);
        applyStimulus("div_by0",      3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b1, 1);
        applyStimulus("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        applyStimulus("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1);

        // Back-pressure: hold result for 10 cycles with a competing request
        @(negedge clk);
        out_ready = 1'b0;
        issue(3'b000, 32'd5, 32'd6);
        waitValid(cycles);
        checkOutput("bp_lat", 32'(cycles), 32'd34);
        in_valid  = 1'b1;
        operand_A = 32'd9;
        operand_B = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_result", result, 32'd30);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_handoff_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_handoff_busy", {31'd0, busy}, 32'd0);
        checkOutput("bp_handoff_ready", {31'd0, in_ready}, 32'd1);

        // Flush at CALC cycle 15
        issue(3'b000, 32'd3, 32'd4);
        for (int i = 0; i < 14; i++) @(negedge clk);
        checkOutput("fl_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("fl_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("fl_in_ready", {31'd0, in_ready}, 32'd1);
        seenValid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seenValid++;
        end
        checkOutput("fl_no_valid", 32'(seenValid), 32'd0);

        // Flush dominates in_valid in IDLE
        @(negedge clk);
        op        = 3'b000;
        operand_A = 32'd2;
        operand_B = 32'd2;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("fl_idle_no_accept", {31'd0, busy}, 32'd0);

        // Reset pulsed in DONE clears out_valid at once
        out_ready = 1'b0;
        issue(3'b101, 32'd123, 32'd0);
        waitValid(cycles);
        checkOutput("rd_valid_before", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rd_valid_cleared", {31'd0, out_valid}, 32'd0);
        checkOutput("rd_result_cleared", result, 32'd0);
        checkOutput("rd_dbz_cleared", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Reset mid-CALC discards the operation
        issue(3'b100, 32'd100, 32'd3);
        for (int i = 0; i < 10; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rc_busy_cleared", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seenValid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seenValid++;
        end
        checkOutput("rc_no_valid", 32'(seenValid), 32'd0);

        // Unit still works after the aborts
        applyStimulus("post_mul", 3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd4, 1'b0, 34);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have one parameter, DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port flush, input, 1 bit, synchronous abort of any in-flight operation.
REQ-005 The block SHALL have port in_valid, input, 1 bit, request present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, sequencer can accept.
REQ-007 The block SHALL have port op, input, 3 bits, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 The block SHALL have ports operand_A and operand_B, input, DATA_WIDTH bits each, rs1 and rs2 values.
REQ-009 The block SHALL have port out_valid, output, 1 bit, result present.
REQ-010 The block SHALL have port out_ready, input, 1 bit, consumer accepts the result.
REQ-011 The block SHALL have port result, output, DATA_WIDTH bits, the RV32M-defined result.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit, qualified by out_valid: a DIV/DIVU/REM/REMU had operand_B == 0.
REQ-013 The block SHALL have port busy, output, 1 bit, high in every state other than IDLE.

Function
REQ-014 The FSM SHALL have four states, IDLE, CALC, FIX and DONE, with in_ready high only in IDLE.
REQ-015 A request SHALL be accepted on the edge where in_valid and in_ready are both high; op and operands are latched on that edge.
REQ-016 Normal path: IDLE->CALC; CALC runs exactly DATA_WIDTH cycles, one radix-2 step per cycle (shift-add for multiply, restoring subtract for divide) on magnitudes; CALC->FIX; FIX applies sign correction and result selection in 1 cycle; FIX->DONE.
REQ-017 out_valid SHALL first be high DATA_WIDTH+2 cycles after the accept edge (34 cycles at default width).
REQ-018 Signedness: MUL/MULH/DIV/REM operands are signed; MULHU/DIVU/REMU are unsigned; MULHSU has A signed and B unsigned.
REQ-019 MUL SHALL return the low half and MULH* the high half of the 2*DATA_WIDTH product.
REQ-020 The quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-021 Fast path for divide by zero: IDLE->DONE directly with out_valid high 1 cycle after accept; quotient all ones, remainder = operand_A, div_by_zero = 1.
REQ-022 Fast path for signed overflow (DIV/REM, A = most-negative value, B = -1): IDLE->DONE in 1 cycle; quotient = A, remainder 0, div_by_zero = 0.
REQ-023 In DONE, result, div_by_zero and out_valid SHALL hold stable until out_ready is high; on that edge the FSM returns to IDLE.
REQ-024 in_ready SHALL NOT combinationally depend on out_ready, so no new request is accepted in the same cycle as a result handoff.
REQ-025 flush SHALL force IDLE on the next edge from any state, dropping any in-flight or unaccepted result, and SHALL dominate in_valid in IDLE so that no accept occurs.
REQ-026 The iteration counter SHALL be $clog2(DATA_WIDTH)+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-027 On rst_n low, the FSM SHALL enter IDLE asynchronously, with out_valid=0, busy=0, result=0, div_by_zero=0 and the counter at 0; in_ready=1 once reset is released.
REQ-028 A reset asserted mid-CALC or in DONE SHALL discard the operation with no out_valid pulse afterwards.

Structure
REQ-029 A shared package SHALL hold the op enum (the funct3 encodings) and the FSM state enum; the ALU_Control codes remain the property of the ALU.
REQ-030 The sequencer SHALL contain one sub-module, muldiv_step: a combinational single radix-2 step for multiply or divide; the FSM, registers and sign fix-up stay in muldiv_sequencer.

Verification
REQ-031 MUL 7 * -3 with out_ready=1 SHALL produce result 0xFFFFFFEB and out_valid exactly 34 cycles after accept.
REQ-032 MULH 0x80000000 * 0x80000000 SHALL produce 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF SHALL produce 0xFFFFFFFE.
REQ-033 DIV -20 / 3 SHALL produce 0xFFFFFFFA; REM -20 % 3 SHALL produce 0xFFFFFFFE.
REQ-034 DIVU 123 / 0 SHALL produce 0xFFFFFFFF with div_by_zero=1 after 1 cycle; REM 123 % 0 SHALL produce 123; DIV 0x80000000 / -1 SHALL produce 0x80000000 after 1 cycle.
REQ-035 Holding out_ready low for 10 cycles in DONE SHALL keep result, out_valid high and in_ready low constant; a concurrent in_valid SHALL NOT be accepted.
REQ-036 flush at CALC cycle 15 SHALL return the block to IDLE next cycle with no out_valid; rst_n pulsed in DONE SHALL clear out_valid immediately.
